// File: rtl/orbit_pkg.sv
// Shared definitions for the orbit frame former: mode encodings, FSM states
// and helpers that derive frame geometry from the selected mode.
package orbit_pkg;

   localparam logic [2:0] MODE_M16 = 3'd0;
   localparam logic [2:0] MODE_M8  = 3'd1;
   localparam logic [2:0] MODE_M4  = 3'd2;
   localparam logic [2:0] MODE_M2  = 3'd3;
   localparam logic [2:0] MODE_M1  = 3'd4;
   localparam logic [2:0] MODE_MAX = MODE_M1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT
   } state_t;

   // Index of the last word in a frame: 2^(addrW-mode) - 1.
   function automatic int unsigned frame_last(input logic [2:0] mode, input int unsigned addrW);
      return (32'd1 << (addrW - 32'(mode))) - 32'd1;
   endfunction

   // Encodings above M1 behave as M1.
   function automatic logic [2:0] clamp_mode(input logic [2:0] mode);
      return (mode > MODE_MAX) ? MODE_MAX : mode;
   endfunction

endpackage

// File: rtl/orbit_bit_timer.sv
// Bit-period divider: counts 0..(BASE_DIV<<mode)-1 and flags the last
// cycle of each bit (strobe) and the first cycle (phase 0).
module orbit_bit_timer #(
   parameter int BASE_DIV = 8,
   parameter int DIV_W    = $clog2(BASE_DIV * 16)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_clear,
   input  logic       i_run,
   input  logic [2:0] i_mode,
   output logic       o_bitStb,
   output logic       o_phase0
);

   logic [DIV_W:0]   w_period;
   logic [DIV_W-1:0] w_tc;
   logic [DIV_W-1:0] r_div;

   assign w_period = (DIV_W + 1)'(BASE_DIV) << i_mode;
   assign w_tc     = DIV_W'(w_period - 1'b1);
   assign o_bitStb = i_run && (r_div == w_tc);
   assign o_phase0 = (r_div == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_div <= '0;
      else if (i_clear)
         r_div <= '0;
      else if (i_run)
         r_div <= o_bitStb ? '0 : r_div + 1'b1;
   end

endmodule

// File: rtl/orbit_frame_former.sv
// Mode-selectable telemetry frame former: fetches words from the filler
// buffer and shifts them out MSB-first as NRZ at a mode-scaled bit rate.
module orbit_frame_former
   import orbit_pkg::*;
#(
   parameter int WORD_W   = 12,
   parameter int ADDR_W   = 11,
   parameter int BASE_DIV = 8,
   parameter int RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iEnable,
   input  logic [2:0]        iMode,
   input  logic [WORD_W-1:0] iWord,
   output logic [ADDR_W-1:0] oAddr,
   output logic              oRdEn,
   output logic              oSerial,
   output logic              oBitStb,
   output logic              oFrameStart,
   output logic              oBusy
);

   localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

   generate
      if (BASE_DIV < RD_LAT + 2) begin : g_divCheck
         $error("BASE_DIV must be at least RD_LAT+2");
      end
      if (RD_LAT < 1 || RD_LAT > 3) begin : g_latCheck
         $error("RD_LAT must be 1 to 3");
      end
   endgenerate

   state_t              r_state, n_state;
   logic [2:0]          r_mode, n_mode;
   logic [ADDR_W-1:0]   r_addr, n_addr;
   logic [ADDR_W-1:0]   r_curIdx, n_curIdx;
   logic [BIT_W-1:0]    r_bit, n_bit;
   logic [WORD_W-1:0]   r_shreg, n_shreg;
   logic [WORD_W-1:0]   r_pf, n_pf;
   logic [RD_LAT-1:0]   r_rdPipe;
   logic                r_rdEn, n_rdEn;
   logic                r_serial, n_serial;
   logic                r_bitStb, n_bitStb;
   logic                r_frameStart, n_frameStart;
   logic                r_busy, n_busy;

   logic                w_timerClear;
   logic                w_wrap;
   logic                w_phase0;
   logic                w_rdTap;
   logic                w_pfCap;
   logic [WORD_W-1:0]   w_pfData;
   logic [2:0]          w_reqMode;
   logic [ADDR_W-1:0]   w_lastIdx;
   logic [BIT_W-1:0]    w_bitInc;

   orbit_bit_timer #(
      .BASE_DIV (BASE_DIV)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .i_clear  (w_timerClear),
      .i_run    (r_state == ST_SHIFT),
      .i_mode   (r_mode),
      .o_bitStb (w_wrap),
      .o_phase0 (w_phase0)
   );

   // The read pipe marks the cycle in which the requested word is on iWord;
   // with the shortest bit period that cycle can coincide with the word boundary.
   assign w_rdTap   = r_rdPipe[RD_LAT-1];
   assign w_pfCap   = (r_state == ST_SHIFT) && w_rdTap;
   assign w_pfData  = w_pfCap ? iWord : r_pf;
   assign w_reqMode = clamp_mode(iMode);
   assign w_lastIdx = ADDR_W'(frame_last(r_mode, ADDR_W));
   assign w_bitInc  = r_bit + 1'b1;

   always_comb begin
      n_state      = r_state;
      n_mode       = r_mode;
      n_addr       = r_addr;
      n_curIdx     = r_curIdx;
      n_bit        = r_bit;
      n_shreg      = r_shreg;
      n_pf         = w_pfData;
      n_rdEn       = 1'b0;
      n_serial     = r_serial;
      n_bitStb     = 1'b0;
      n_frameStart = 1'b0;
      n_busy       = r_busy;
      w_timerClear = 1'b0;
      case (r_state)
         ST_IDLE: begin
            n_serial = 1'b0;
            n_busy   = 1'b0;
            if (iEnable) begin
               n_mode  = w_reqMode;
               n_addr  = '0;
               n_rdEn  = 1'b1;
               n_busy  = 1'b1;
               n_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (w_rdTap) begin
               n_shreg      = iWord;
               n_serial     = iWord[WORD_W-1];
               n_bit        = '0;
               n_curIdx     = '0;
               n_frameStart = 1'b1;
               n_bitStb     = 1'b1;
               w_timerClear = 1'b1;
               n_state      = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_phase0 && r_bit == LAST_BIT) begin
               n_rdEn = 1'b1;
               n_addr = (r_addr == w_lastIdx) ? '0 : r_addr + 1'b1;
            end
            if (w_wrap) begin
               n_bitStb = 1'b1;
               if (r_bit != LAST_BIT) begin
                  n_bit    = w_bitInc;
                  n_serial = r_shreg[LAST_BIT - w_bitInc];
               end else if (r_curIdx != w_lastIdx) begin
                  n_shreg  = w_pfData;
                  n_serial = w_pfData[WORD_W-1];
                  n_bit    = '0;
                  n_curIdx = r_curIdx + 1'b1;
               end else if (iEnable && w_reqMode == r_mode) begin
                  n_shreg      = w_pfData;
                  n_serial     = w_pfData[WORD_W-1];
                  n_bit        = '0;
                  n_curIdx     = '0;
                  n_frameStart = 1'b1;
               end else if (iEnable) begin
                  // The wrapped prefetch was addressed under the old frame length.
                  n_mode   = w_reqMode;
                  n_addr   = '0;
                  n_rdEn   = 1'b1;
                  n_serial = 1'b0;
                  n_bitStb = 1'b0;
                  n_state  = ST_LOAD;
               end else begin
                  n_serial = 1'b0;
                  n_bitStb = 1'b0;
                  n_busy   = 1'b0;
                  n_state  = ST_IDLE;
               end
            end
         end
         default: n_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_mode       <= '0;
         r_addr       <= '0;
         r_curIdx     <= '0;
         r_bit        <= '0;
         r_shreg      <= '0;
         r_pf         <= '0;
         r_rdPipe     <= '0;
         r_rdEn       <= 1'b0;
         r_serial     <= 1'b0;
         r_bitStb     <= 1'b0;
         r_frameStart <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= n_state;
         r_mode       <= n_mode;
         r_addr       <= n_addr;
         r_curIdx     <= n_curIdx;
         r_bit        <= n_bit;
         r_shreg      <= n_shreg;
         r_pf         <= n_pf;
         r_rdPipe     <= RD_LAT'({r_rdPipe, r_rdEn});
         r_rdEn       <= n_rdEn;
         r_serial     <= n_serial;
         r_bitStb     <= n_bitStb;
         r_frameStart <= n_frameStart;
         r_busy       <= n_busy;
      end
   end

   assign oAddr       = r_addr;
   assign oRdEn       = r_rdEn;
   assign oSerial     = r_serial;
   assign oBitStb     = r_bitStb;
   assign oFrameStart = r_frameStart;
   assign oBusy       = r_busy;

endmodule

// File: tb/tb_orbit_frame_former.sv
// Directed bench for orbit_frame_former with a scaled-down geometry
// (8-bit words, 32-word M16 frame, 3-clock M16 bit) and a 1-cycle buffer.
module tb_orbit_frame_former;

   localparam int WORD_W   = 8;
   localparam int ADDR_W   = 5;
   localparam int BASE_DIV = 3;
   localparam int RD_LAT   = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              iEnable = 1'b0;
   logic [2:0]        iMode = 3'd0;
   logic [WORD_W-1:0] iWord;
   logic [ADDR_W-1:0] oAddr;
   logic              oRdEn;
   logic              oSerial;
   logic              oBitStb;
   logic              oFrameStart;
   logic              oBusy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rdCount = 0;
   int lastRdAddr = -1;
   int prevRdAddr = -1;
   int lastRdCyc = 0;
   int rdInterval = 0;
   logic h1 = 1'b0;
   logic h2 = 1'b0;

   orbit_frame_former #(
      .WORD_W   (WORD_W),
      .ADDR_W   (ADDR_W),
      .BASE_DIV (BASE_DIV),
      .RD_LAT   (RD_LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .iEnable     (iEnable),
      .iMode       (iMode),
      .iWord       (iWord),
      .oAddr       (oAddr),
      .oRdEn       (oRdEn),
      .oSerial     (oSerial),
      .oBitStb     (oBitStb),
      .oFrameStart (oFrameStart),
      .oBusy       (oBusy)
   );

   always #5 clk = ~clk;

   // Cycle counter plus a one-cycle-latency buffer holding {101, address};
   // non-read cycles present filler so a mistimed capture shows up.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      iWord <= oRdEn ? {3'b101, oAddr} : 8'h5A;
      if (oRdEn) begin
         rdCount    <= rdCount + 1;
         prevRdAddr <= lastRdAddr;
         lastRdAddr <= int'(oAddr);
         rdInterval <= cyc - lastRdCyc;
         lastRdCyc  <= cyc;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [2:0] mode);
      iEnable = en;
      iMode   = mode;
   endtask

   task automatic getBit(output logic b, output logic fs, output int dt);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!oBitStb) begin
            h2 = h1;
            h1 = oSerial;
         end
      end while (!oBitStb && n < 100);
      if (!oBitStb) checkOutput("bitTimeout", 32'(oBitStb), 32'd1);
      b  = oSerial;
      fs = oFrameStart;
      dt = n;
   endtask

   task automatic collectWord(input logic first, input int expP, output logic [7:0] w, output int badP);
      logic b, fs;
      int dt;
      w = {7'b0, first};
      badP = 0;
      repeat (7) begin
         getBit(b, fs, dt);
         w = {w[6:0], b};
         if (dt != expP) badP++;
      end
   endtask

   task automatic waitFrame(output logic first, output int dt);
      logic fs;
      int k;
      k = 0;
      do begin
         getBit(first, fs, dt);
         k++;
      end while (!fs && k < 300);
      checkOutput("frameFound", 32'(fs), 32'd1);
   endtask

   initial begin
      logic [7:0] w;
      logic b, fs;
      int dt, bad, fs1Cyc, fs3Cyc, stb, since, k, rdSnap;

      repeat (3) @(negedge clk);
      checkOutput("resetOutputs", 32'({oSerial, oBitStb, oFrameStart, oRdEn, oBusy, oAddr}), 32'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("idleQuiet", 32'({oSerial, oBitStb, oFrameStart, oRdEn, oBusy, oAddr}), 32'd0);

      // M16 start latency and first words
      applyStimulus(1'b1, 3'd0);
      @(negedge clk);
      checkOutput("startRdEn", 32'(oRdEn), 32'd1);
      checkOutput("startAddr", 32'(oAddr), 32'd0);
      checkOutput("startBusy", 32'(oBusy), 32'd1);
      @(negedge clk);
      checkOutput("loadNoFrameStart", 32'(oFrameStart), 32'd0);
      @(negedge clk);
      checkOutput("firstBitFsStb", 32'({oFrameStart, oBitStb, oSerial}), 32'b111);
      fs1Cyc = cyc;
      collectWord(oSerial, 3, w, bad);
      checkOutput("m16Word0", 32'(w), 32'hA0);
      checkOutput("m16Period", 32'(bad), 32'd0);
      getBit(b, fs, dt);
      checkOutput("word1NoFs", 32'(fs), 32'd0);
      checkOutput("word1Gapless", 32'(dt), 32'd3);
      collectWord(b, 3, w, bad);
      checkOutput("m16Word1", 32'(w), 32'hA1);
      getBit(b, fs, dt);
      collectWord(b, 3, w, bad);
      checkOutput("m16Word2", 32'(w), 32'hA2);
      checkOutput("rdInterval", 32'(rdInterval), 32'd24);
      checkOutput("rdAddrWord2", 32'(lastRdAddr), 32'd2);

      // Seamless M16 frame repeat with address wrap 31 -> 0
      waitFrame(b, dt);
      checkOutput("m16FrameGapless", 32'(dt), 32'd3);
      checkOutput("m16FrameLen", 32'(cyc - fs1Cyc), 32'd768);
      checkOutput("wrapAddrLast", 32'(prevRdAddr), 32'd31);
      checkOutput("wrapAddrZero", 32'(lastRdAddr), 32'd0);
      collectWord(b, 3, w, bad);
      checkOutput("m16Frame2Word0", 32'(w), 32'hA0);

      // iMode=6 requested mid-frame: ignored until the boundary, then acts as M1
      applyStimulus(1'b1, 3'd6);
      getBit(b, fs, dt);
      checkOutput("midFrameModeIgnored", 32'(dt), 32'd3);
      waitFrame(b, dt);
      checkOutput("m1GapLen", 32'(dt), 32'd5);
      checkOutput("m1GapZero", 32'({h2, h1}), 32'd0);
      checkOutput("m1LoadAddr", 32'(lastRdAddr), 32'd0);
      fs3Cyc = cyc;
      collectWord(b, 48, w, bad);
      checkOutput("m1Word0", 32'(w), 32'hA0);
      checkOutput("m1Period", 32'(bad), 32'd0);

      // iMode=4 is the same mode as 6: next frame follows without a gap
      applyStimulus(1'b1, 3'd4);
      getBit(b, fs, dt);
      checkOutput("m1Word1Bit0", 32'({fs, 8'(dt)}), 32'd48);
      collectWord(b, 48, w, bad);
      checkOutput("m1Word1", 32'(w), 32'hA1);
      waitFrame(b, dt);
      checkOutput("m1FrameGapless", 32'(dt), 32'd48);
      checkOutput("m1FrameLen", 32'(cyc - fs3Cyc), 32'd768);
      checkOutput("m1AddrPrev", 32'(prevRdAddr), 32'd1);
      checkOutput("m1AddrWrap", 32'(lastRdAddr), 32'd0);

      // Switch M1 -> M2 at the boundary
      applyStimulus(1'b1, 3'd3);
      waitFrame(b, dt);
      checkOutput("m2GapLen", 32'(dt), 32'd50);
      checkOutput("m2GapZero", 32'({h2, h1}), 32'd0);
      collectWord(b, 24, w, bad);
      checkOutput("m2Word0", 32'(w), 32'hA0);
      checkOutput("m2Period", 32'(bad), 32'd0);

      // Drop iEnable mid-frame: the frame completes (words 1..3), then IDLE
      applyStimulus(1'b0, 3'd3);
      stb = 0;
      since = 0;
      k = 0;
      while (oBusy && k < 2000) begin
         @(negedge clk);
         k++;
         since++;
         if (oBitStb) begin
            stb++;
            since = 0;
         end
      end
      checkOutput("stopRemainingBits", 32'(stb), 32'd24);
      checkOutput("stopLastBitLen", 32'(since), 32'd24);
      checkOutput("stopBusy", 32'(oBusy), 32'd0);
      checkOutput("stopSerial", 32'(oSerial), 32'd0);
      checkOutput("stopAddrPrev", 32'(prevRdAddr), 32'd3);
      checkOutput("stopAddrWrap", 32'(lastRdAddr), 32'd0);
      rdSnap = rdCount;
      repeat (30) @(negedge clk);
      checkOutput("idleNoReads", 32'(rdCount), 32'(rdSnap));
      checkOutput("idleBusy", 32'(oBusy), 32'd0);

      // Reset during SHIFT, then restart
      applyStimulus(1'b1, 3'd0);
      repeat (40) @(negedge clk);
      checkOutput("preResetBusy", 32'(oBusy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midResetOutputs", 32'({oSerial, oBitStb, oFrameStart, oRdEn, oBusy, oAddr}), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("restartRdEn", 32'(oRdEn), 32'd1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("restartFirstBit", 32'({oFrameStart, oBitStb, oSerial}), 32'b111);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
